// File: rtl/alu_seq_pkg.sv
// rtl/alu_seq_pkg.sv - opcodes and state encoding shared by the ALU vector sequencer
package alu_seq_pkg;

  localparam logic [3:0] OP_ADD       = 4'd1;
  localparam logic [3:0] OP_SUB       = 4'd2;
  localparam logic [3:0] OP_XOR       = 4'd3;
  localparam logic [3:0] OP_AND       = 4'd4;
  localparam logic [3:0] OP_OR        = 4'd5;
  localparam logic [3:0] OP_MOVS      = 4'd6;
  localparam logic [3:0] OP_MOVSR     = 4'd7;
  localparam logic [3:0] OP_SHL       = 4'd8;
  localparam logic [3:0] OP_SHR       = 4'd9;
  localparam logic [3:0] OP_ROR       = 4'd10;
  localparam logic [3:0] OP_ROL       = 4'd11;
  localparam logic [3:0] OP_MAX_LEGAL = 4'd11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_FIN   = 2'd3
  } seq_state_t;

endpackage

// File: rtl/alu_seq_agen.sv
// rtl/alu_seq_agen.sv - element counters and wrapping base+index address adders
module alu_seq_agen #(
  parameter int ADDR_W = 5,
  parameter int LEN_W  = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_clear,
  input  logic              i_issue,
  input  logic              i_wadv,
  input  logic [ADDR_W-1:0] i_src_a,
  input  logic [ADDR_W-1:0] i_src_b,
  input  logic [ADDR_W-1:0] i_dst,
  input  logic [LEN_W-1:0]  i_len,
  output logic [ADDR_W-1:0] o_raddr_a,
  output logic [ADDR_W-1:0] o_raddr_b,
  output logic [ADDR_W-1:0] o_waddr,
  output logic              o_last
);

  logic [LEN_W-1:0] r_ridx;
  logic [LEN_W-1:0] r_widx;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ridx <= '0;
      r_widx <= '0;
    end else if (i_clear) begin
      r_ridx <= '0;
      r_widx <= '0;
    end else begin
      if (i_issue) r_ridx <= r_ridx + LEN_W'(1);
      if (i_wadv)  r_widx <= r_widx + LEN_W'(1);
    end
  end

  // Truncating the index to ADDR_W gives the modulo-2^ADDR_W wrap for free.
  assign o_raddr_a = i_src_a + ADDR_W'(r_ridx);
  assign o_raddr_b = i_src_b + ADDR_W'(r_ridx);
  assign o_waddr   = i_dst + ADDR_W'(r_widx);
  assign o_last    = (r_ridx == i_len - LEN_W'(1));

endmodule

// File: rtl/alu_vec_sequencer.sv
// rtl/alu_vec_sequencer.sv - sequences the shared ALU over register-file vectors
// (define ALU_SEQ_STATUS_EN to add the status_zero output)
module alu_vec_sequencer
  import alu_seq_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int OP_W   = 4,
  parameter int ADDR_W = 5,
  parameter int LEN_W  = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [OP_W-1:0]   cmd_op,
  input  logic [ADDR_W-1:0] cmd_src_a,
  input  logic [ADDR_W-1:0] cmd_src_b,
  input  logic [ADDR_W-1:0] cmd_dst,
  input  logic [LEN_W-1:0]  cmd_len,
  output logic [ADDR_W-1:0] rf_raddr_a,
  output logic [ADDR_W-1:0] rf_raddr_b,
  input  logic [DATA_W-1:0] rf_rdata_a,
  input  logic [DATA_W-1:0] rf_rdata_b,
  output logic [OP_W-1:0]   alu_function,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  input  logic [DATA_W-1:0] alu_result,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic              busy,
  output logic              done,
  output logic              err
`ifdef ALU_SEQ_STATUS_EN
  ,
  output logic              status_zero
`endif
);

  seq_state_t        r_state, w_next;
  logic [OP_W-1:0]   r_op;
  logic [ADDR_W-1:0] r_src_a, r_src_b, r_dst;
  logic [LEN_W-1:0]  r_len;
  logic              r_err, r_alive, r_ex_vld, r_we;
  logic [ADDR_W-1:0] r_waddr;
  logic [DATA_W-1:0] r_wdata;
  logic [ADDR_W-1:0] w_raddr_a, w_raddr_b, w_waddr;
  logic              w_last, w_accept, w_op_legal;

  assign w_op_legal = (cmd_op != '0) && (cmd_op <= OP_W'(OP_MAX_LEGAL));
  assign w_accept   = cmd_valid && cmd_ready;

  alu_seq_agen #(.ADDR_W(ADDR_W), .LEN_W(LEN_W)) u_agen (
    .clk       (clk),
    .reset     (reset),
    .i_clear   (w_accept),
    .i_issue   (r_state == ST_ISSUE),
    .i_wadv    (r_ex_vld),
    .i_src_a   (r_src_a),
    .i_src_b   (r_src_b),
    .i_dst     (r_dst),
    .i_len     (r_len),
    .o_raddr_a (w_raddr_a),
    .o_raddr_b (w_raddr_b),
    .o_waddr   (w_waddr),
    .o_last    (w_last)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next       = r_state;
    cmd_ready    = 1'b0;
    busy         = 1'b0;
    done         = 1'b0;
    err          = 1'b0;
    rf_raddr_a   = '0;
    rf_raddr_b   = '0;
    alu_function = '0;
    alu_a        = '0;
    alu_b        = '0;
    unique case (r_state)
      ST_IDLE: begin
        cmd_ready = r_alive;
        if (w_accept) w_next = (!w_op_legal || cmd_len == '0) ? ST_FIN : ST_ISSUE;
      end
      ST_ISSUE: begin
        busy       = 1'b1;
        rf_raddr_a = w_raddr_a;
        rf_raddr_b = w_raddr_b;
        if (w_last) w_next = ST_DRAIN;
      end
      ST_DRAIN: begin
        busy = 1'b1;
        // Last write is on the bus and nothing is left in the execute stage.
        if (r_we && !r_ex_vld) w_next = ST_FIN;
      end
      ST_FIN: begin
        busy   = 1'b1;
        done   = 1'b1;
        err    = r_err;
        w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
    if (r_ex_vld) begin
      alu_function = r_op;
      alu_a        = rf_rdata_a;
      alu_b        = rf_rdata_b;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_alive  <= 1'b0;
      r_op     <= '0;
      r_src_a  <= '0;
      r_src_b  <= '0;
      r_dst    <= '0;
      r_len    <= '0;
      r_err    <= 1'b0;
      r_ex_vld <= 1'b0;
      r_we     <= 1'b0;
      r_waddr  <= '0;
      r_wdata  <= '0;
    end else begin
      r_alive <= 1'b1;
      if (w_accept) begin
        r_op    <= cmd_op;
        r_src_a <= cmd_src_a;
        r_src_b <= cmd_src_b;
        r_dst   <= cmd_dst;
        r_len   <= cmd_len;
        r_err   <= !w_op_legal;
      end
      r_ex_vld <= (r_state == ST_ISSUE);
      r_we     <= r_ex_vld;
      r_waddr  <= r_ex_vld ? w_waddr : '0;
      r_wdata  <= r_ex_vld ? alu_result : '0;
    end
  end

  assign rf_we    = r_we;
  assign rf_waddr = r_waddr;
  assign rf_wdata = r_wdata;

`ifdef ALU_SEQ_STATUS_EN
  logic r_zero_acc, r_status_zero, w_zero_acc;

  // Illegal ops start the accumulator low so they always report non-zero.
  assign w_zero_acc = w_accept ? w_op_legal : (r_zero_acc & ~(r_we & (|r_wdata)));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_zero_acc    <= 1'b0;
      r_status_zero <= 1'b0;
    end else begin
      r_zero_acc <= w_zero_acc;
      if (r_state != ST_FIN && w_next == ST_FIN) r_status_zero <= w_zero_acc;
    end
  end

  assign status_zero = r_status_zero;
`endif

endmodule

// File: tb/tb_alu_vec_sequencer.sv
// tb/tb_alu_vec_sequencer.sv - scoreboard bench for alu_vec_sequencer with RF and ALU models
module tb_alu_vec_sequencer;
  import alu_seq_pkg::*;

  logic       clk, reset;
  logic       cmd_valid, cmd_ready;
  logic [3:0] cmd_op;
  logic [4:0] cmd_src_a, cmd_src_b, cmd_dst;
  logic [5:0] cmd_len;
  logic [4:0] rf_raddr_a, rf_raddr_b, rf_waddr;
  logic [7:0] rf_rdata_a, rf_rdata_b, rf_wdata;
  logic [3:0] alu_function;
  logic [7:0] alu_a, alu_b, alu_result;
  logic       rf_we, busy, done, err;
`ifdef ALU_SEQ_STATUS_EN
  logic       status_zero;
`endif

  alu_vec_sequencer dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_src_a(cmd_src_a), .cmd_src_b(cmd_src_b), .cmd_dst(cmd_dst), .cmd_len(cmd_len),
    .rf_raddr_a(rf_raddr_a), .rf_raddr_b(rf_raddr_b),
    .rf_rdata_a(rf_rdata_a), .rf_rdata_b(rf_rdata_b),
    .alu_function(alu_function), .alu_a(alu_a), .alu_b(alu_b), .alu_result(alu_result),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .busy(busy), .done(done), .err(err)
`ifdef ALU_SEQ_STATUS_EN
    , .status_zero(status_zero)
`endif
  );

  typedef struct {
    logic [4:0] addr;
    logic [7:0] data;
    int         cyc;
  } wr_t;

  wr_t        sbq[$];
  wr_t        mon_e;
  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  logic [7:0] rf [32];
  logic       pl_we;
  logic [4:0] pl_addr;
  logic [7:0] pl_data;

  function automatic logic [7:0] alu_f(input logic [3:0] f, input logic [7:0] a, input logic [7:0] b);
    case (f)
      OP_ADD:   return a + b;
      OP_SUB:   return a - b;
      OP_XOR:   return a ^ b;
      OP_AND:   return a & b;
      OP_OR:    return a | b;
      OP_MOVS:  return a;
      OP_MOVSR: return b;
      OP_SHL:   return a << 1;
      OP_SHR:   return a >> 1;
      OP_ROR:   return {a[0], a[7:1]};
      OP_ROL:   return {a[6:0], a[7]};
      default:  return 8'h00;
    endcase
  endfunction

  assign alu_result = alu_f(alu_function, alu_a, alu_b);

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    rf_rdata_a <= rf[rf_raddr_a];
    rf_rdata_b <= rf[rf_raddr_b];
    if (rf_we) rf[rf_waddr] <= rf_wdata;
    if (pl_we) rf[pl_addr] <= pl_data;
  end

  always @(negedge clk) begin
    if (rf_we) begin
      checks++;
      if (sbq.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: got addr=%0d data=%0d at cycle %0d, none expected", rf_waddr, rf_wdata, cyc + 1);
      end else begin
        mon_e = sbq.pop_front();
        if (rf_waddr !== mon_e.addr || rf_wdata !== mon_e.data || cyc + 1 != mon_e.cyc) begin
          errors++;
          $display("FAIL write: got addr=%0d data=%0d cyc=%0d, expected addr=%0d data=%0d cyc=%0d",
                   rf_waddr, rf_wdata, cyc + 1, mon_e.addr, mon_e.data, mon_e.cyc);
        end
      end
    end
  end

  task automatic rf_set(input logic [4:0] a, input logic [7:0] d);
    pl_we = 1'b1; pl_addr = a; pl_data = d;
    @(negedge clk);
    pl_we = 1'b0;
  endtask

  // Drives one command; t is the accept edge. Returns in the first cycle after accept.
  task automatic send_cmd(input logic [3:0] op, input logic [4:0] sa, input logic [4:0] sbb,
                          input logic [4:0] d, input logic [5:0] len, output int t);
    int n = 0;
    while (!cmd_ready && n < 100) begin @(negedge clk); n++; end
    cmd_valid = 1'b1; cmd_op = op; cmd_src_a = sa; cmd_src_b = sbb; cmd_dst = d; cmd_len = len;
    t = cyc + 1;
    if (op != 4'd0 && op <= 4'd11) begin
      for (int i = 0; i < int'(len); i++) begin
        wr_t w;
        w.addr = d + 5'(i);
        w.data = alu_f(op, rf[sa + 5'(i)], rf[sbb + 5'(i)]);
        w.cyc  = t + 3 + i;
        sbq.push_back(w);
      end
    end
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_op = 4'($urandom); cmd_src_a = 5'($urandom); cmd_src_b = 5'($urandom);
    cmd_dst = 5'($urandom); cmd_len = 6'($urandom);
  endtask

  task automatic wait_done(output int dc, output logic de);
    dc = -1; de = 1'b0;
    for (int k = 0; k < 200; k++) begin
      if (done) begin dc = cyc + 1; de = err; break; end
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({cmd_ready, busy, done, err, rf_we} !== 5'b0) begin
      errors++; $display("FAIL reset_ctrl: got %b, expected 00000", {cmd_ready, busy, done, err, rf_we});
    end
    checks++;
    if ({rf_raddr_a, rf_raddr_b, rf_waddr, rf_wdata, alu_function, alu_a, alu_b} !== 51'b0) begin
      errors++; $display("FAIL reset_data: got %h, expected 0", {rf_raddr_a, rf_raddr_b, rf_waddr, rf_wdata, alu_function, alu_a, alu_b});
    end
    reset = 1'b0;
    #1;
    checks++;
    if (cmd_ready !== 1'b0) begin errors++; $display("FAIL ready_at_release: got %b, expected 0", cmd_ready); end
    @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b1) begin errors++; $display("FAIL ready_after_reset: got %b, expected 1", cmd_ready); end
  endtask

  task automatic test_add_wrap;
    int t, dc; logic de;
    rf_set(0, 1); rf_set(1, 2); rf_set(2, 3); rf_set(3, 250);
    rf_set(8, 1); rf_set(9, 1); rf_set(10, 1); rf_set(11, 10);
    send_cmd(OP_ADD, 0, 8, 16, 4, t);
    checks++;
    if (busy !== 1'b1 || rf_raddr_a !== 5'd0 || rf_raddr_b !== 5'd8) begin
      errors++; $display("FAIL add_first_read: got busy=%b ra=%0d rb=%0d, expected 1 0 8", busy, rf_raddr_a, rf_raddr_b);
    end
    wait_done(dc, de);
    checks++;
    if (dc != t + 7 || de !== 1'b0) begin
      errors++; $display("FAIL add_done: got cyc=%0d err=%b, expected cyc=%0d err=0", dc, de, t + 7);
    end
    @(negedge clk);
    checks++;
    if ({rf[16], rf[17], rf[18], rf[19]} !== {8'd2, 8'd3, 8'd4, 8'd4}) begin
      errors++; $display("FAIL add_rf: got %h, expected 02030404", {rf[16], rf[17], rf[18], rf[19]});
    end
    checks++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0 || alu_function !== 4'd0 || sbq.size() != 0) begin
      errors++; $display("FAIL add_idle: got ready=%b busy=%b fn=%0d pend=%0d, expected 1 0 0 0", cmd_ready, busy, alu_function, sbq.size());
    end
  endtask

  task automatic test_addr_wrap;
    int t, dc; logic de;
    logic [4:0] ea, eb;
    rf_set(30, 50); rf_set(31, 60); rf_set(0, 70); rf_set(1, 5);
    rf_set(4, 7); rf_set(5, 61); rf_set(6, 3); rf_set(7, 9);
    send_cmd(OP_SUB, 30, 4, 30, 4, t);
    for (int i = 0; i < 4; i++) begin
      ea = 5'd30 + 5'(i); eb = 5'd4 + 5'(i);
      checks++;
      if (rf_raddr_a !== ea || rf_raddr_b !== eb) begin
        errors++; $display("FAIL wrap_read%0d: got a=%0d b=%0d, expected a=%0d b=%0d", i, rf_raddr_a, rf_raddr_b, ea, eb);
      end
      @(negedge clk);
    end
    wait_done(dc, de);
    checks++;
    if (dc != t + 7) begin errors++; $display("FAIL wrap_done: got cyc=%0d, expected %0d", dc, t + 7); end
  endtask

  task automatic test_illegal;
    int t;
    logic [3:0] ops [2];
    ops[0] = 4'd0; ops[1] = 4'd13;
    for (int k = 0; k < 2; k++) begin
      send_cmd(ops[k], 0, 8, 20, 5, t);
      checks++;
      if ({done, err} !== 2'b11) begin
        errors++; $display("FAIL illegal_done op=%0d: got done=%b err=%b, expected 1 1", ops[k], done, err);
      end
      @(negedge clk);
      checks++;
      if (cmd_ready !== 1'b1 || done !== 1'b0) begin
        errors++; $display("FAIL illegal_ready op=%0d: got ready=%b done=%b, expected 1 0", ops[k], cmd_ready, done);
      end
      repeat (6) @(negedge clk);
    end
  endtask

  task automatic test_len0;
    int t;
    send_cmd(OP_XOR, 0, 8, 20, 0, t);
    checks++;
    if ({done, err} !== 2'b10) begin
      errors++; $display("FAIL len0_done: got done=%b err=%b, expected 1 0", done, err);
    end
    repeat (5) @(negedge clk);
  endtask

  task automatic test_back_to_back;
    int t1, t2, dc; logic de;
    for (int i = 0; i < 6; i++) begin
      rf_set(5'(i), 8'($urandom));
      rf_set(5'(10 + i), 8'($urandom));
    end
    send_cmd(OP_ROL, 0, 10, 20, 6, t1);
    send_cmd(OP_AND, 20, 10, 26, 6, t2);
    checks++;
    if (t2 - t1 != 10) begin errors++; $display("FAIL b2b_gap: got %0d, expected 10", t2 - t1); end
    wait_done(dc, de);
    checks++;
    if (dc != t2 + 9 || de !== 1'b0) begin
      errors++; $display("FAIL b2b_done: got cyc=%0d err=%b, expected cyc=%0d err=0", dc, de, t2 + 9);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset_mid;
    int t, dc; logic de;
    rf_set(22, 8'hEE);
    send_cmd(OP_ADD, 0, 8, 20, 8, t);
    repeat (3) @(negedge clk);
    #1;
    reset = 1'b1;
    sbq.delete();
    #1;
    checks++;
    if ({cmd_ready, busy, done, err, rf_we, rf_raddr_a, rf_raddr_b, rf_waddr, rf_wdata, alu_function, alu_a, alu_b} !== 56'b0) begin
      errors++; $display("FAIL abort_outputs: got %h, expected 0",
        {cmd_ready, busy, done, err, rf_we, rf_raddr_a, rf_raddr_b, rf_waddr, rf_wdata, alu_function, alu_a, alu_b});
    end
    repeat (2) @(negedge clk);
    #1 reset = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || rf_we !== 1'b0) begin
        errors++; $display("FAIL abort_quiet%0d: got done=%b we=%b, expected 0 0", i, done, rf_we);
      end
    end
    checks++;
    if (rf[22] !== 8'hEE) begin errors++; $display("FAIL abort_rf: got %h, expected ee", rf[22]); end
    send_cmd(OP_OR, 1, 9, 24, 3, t);
    wait_done(dc, de);
    checks++;
    if (dc != t + 6 || de !== 1'b0) begin
      errors++; $display("FAIL post_abort_done: got cyc=%0d err=%b, expected cyc=%0d err=0", dc, de, t + 6);
    end
    repeat (2) @(negedge clk);
  endtask

`ifdef ALU_SEQ_STATUS_EN
  task automatic test_status;
    int t, dc; logic de;
    for (int i = 0; i < 5; i++) begin
      rf_set(5'(i), 8'(i * 37 + 1));
      rf_set(5'(8 + i), 8'(i * 37 + 1));
    end
    send_cmd(OP_XOR, 0, 0, 24, 5, t);
    wait_done(dc, de);
    checks++;
    if (status_zero !== 1'b1) begin errors++; $display("FAIL status_all_zero: got %b, expected 1", status_zero); end
    rf_set(11, 8'h5A);
    send_cmd(OP_XOR, 0, 8, 24, 5, t);
    wait_done(dc, de);
    checks++;
    if (status_zero !== 1'b0) begin errors++; $display("FAIL status_nonzero: got %b, expected 0", status_zero); end
    repeat (2) @(negedge clk);
  endtask
`endif

  initial begin
    reset = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_src_a = '0; cmd_src_b = '0;
    cmd_dst = '0; cmd_len = '0; pl_we = 1'b0; pl_addr = '0; pl_data = '0;
    test_reset();
    test_add_wrap();
    test_addr_wrap();
    test_illegal();
    test_len0();
    test_back_to_back();
    test_reset_mid();
`ifdef ALU_SEQ_STATUS_EN
    test_status();
`endif
    checks++;
    if (sbq.size() != 0) begin errors++; $display("FAIL pending_writes: got %0d, expected 0", sbq.size()); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
